// File: rtl/cisc_seq_ctrl.sv
// cisc_seq_ctrl: 8-phase instruction sequencer for the 8-bit accumulator CISC core.
// Each instruction takes a fixed fetch/execute cycle. The phase counter advances
// every clock until a HLT stops it. All control strobes are combinational decodes
// of (phase, opcode, zero, halted), so they follow the phase with no added latency.
//
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   asynchronous, active-high; phase -> INST_ADDR, halted -> 0
//   opcode  in   IR[7:5]; only decoded in phases 4..7
//   zero    in   accumulator==0 flag; only used in phase 6 (SKZ)
//   sel     out  address mux select, 1=PC, 0=IR operand address
//   rd      out  memory read enable
//   wr      out  memory write strobe
//   ld_ir   out  instruction register load
//   inc_pc  out  PC increment request
//   ld_pc   out  PC load from IR[4:0] (the PC gives it priority over inc_pc)
//   ld_ac   out  accumulator load
//   data_e  out  accumulator drives the data bus
//   halted  out  sequencer is stopped
//   phase   out  current phase, for debug
module cisc_seq_ctrl #(
  parameter int PHASE_W = 3,
  parameter int OP_W    = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    opcode,
  input  logic               zero,
  output logic               sel,
  output logic               rd,
  output logic               wr,
  output logic               ld_ir,
  output logic               inc_pc,
  output logic               ld_pc,
  output logic               ld_ac,
  output logic               data_e,
  output logic               halted,
  output logic [PHASE_W-1:0] phase
);

  typedef enum logic [PHASE_W-1:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  localparam logic [OP_W-1:0] OP_HLT = 3'd0;
  localparam logic [OP_W-1:0] OP_SKZ = 3'd1;
  localparam logic [OP_W-1:0] OP_ADD = 3'd2;
  localparam logic [OP_W-1:0] OP_AND = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR = 3'd4;
  localparam logic [OP_W-1:0] OP_LDA = 3'd5;
  localparam logic [OP_W-1:0] OP_STO = 3'd6;
  localparam logic [OP_W-1:0] OP_JMP = 3'd7;

  phase_t             state;
  logic               halt_q;
  logic [PHASE_W-1:0] next_phase;
  logic               alu_op;

  // Natural 3-bit wrap takes phase 7 straight back to 0.
  assign next_phase = state + 3'd1;

  // Sequencer state. A HLT seen in OP_ADDR sets halt_q on the same edge that
  // moves the phase to OP_FETCH; from then on the phase is frozen at 5.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= INST_ADDR;
      halt_q <= 1'b0;
    end else if (!halt_q) begin
      state <= phase_t'(next_phase);
      if (state == OP_ADDR && opcode == OP_HLT) begin
        halt_q <= 1'b1;
      end
    end
  end

  // Instructions that read an operand from memory into the ALU path.
  assign alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                  (opcode == OP_XOR) || (opcode == OP_LDA);

  // Strobe decode. Phases 0..3 ignore opcode entirely because the IR is still
  // being loaded; a halted sequencer drives every strobe and sel low.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    data_e = 1'b0;
    if (!halt_q) begin
      case (state)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = (opcode != OP_HLT);
        end
        OP_FETCH: begin
          rd = alu_op;
        end
        ALU_OP: begin
          rd     = alu_op;
          inc_pc = (opcode == OP_SKZ) && zero;  // second increment skips a word
          ld_pc  = (opcode == OP_JMP);          // overrides the phase-4 increment
          data_e = (opcode == OP_STO);
        end
        STORE: begin
          rd     = alu_op;
          ld_ac  = alu_op;
          ld_pc  = (opcode == OP_JMP);
          wr     = (opcode == OP_STO);
          data_e = (opcode == OP_STO);
        end
        default: begin
        end
      endcase
    end
  end

  assign halted = halt_q;
  assign phase  = state;

endmodule

// File: tb/tb_cisc_seq_ctrl.sv
// Bench for cisc_seq_ctrl. Inputs change on the falling edge and outputs are
// sampled 2 ns later. Expected strobes come from per-instruction phase masks;
// a PC stub tracks ld_pc/inc_pc and is compared against the arithmetic result
// each instruction should leave (JMP -> target, SKZ -> +1/+2, HLT -> hold).
module tb_cisc_seq_ctrl;

  localparam logic [2:0] HLT = 3'd0;
  localparam logic [2:0] SKZ = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] AND = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] LDA = 3'd5;
  localparam logic [2:0] STO = 3'd6;
  localparam logic [2:0] JMP = 3'd7;

  // clock/reset
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] opcode = 3'd0;
  logic       zero = 1'b0;
  logic       sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halted;
  logic [2:0] phase;
  logic [8:0] obs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cisc_seq_ctrl #(.PHASE_W(3), .OP_W(3)) dut (
    .clk    (clk),
    .reset  (reset),
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .wr     (wr),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .ld_ac  (ld_ac),
    .data_e (data_e),
    .halted (halted),
    .phase  (phase)
  );

  assign obs = {sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halted};

  task automatic check(input string tag, input logic [15:0] o, input logic [15:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Hold reset across two edges, verify the reset decode, then release.
  task automatic do_reset();
    reset  = 1'b1;
    opcode = 3'($urandom_range(0, 7));
    zero   = 1'($urandom_range(0, 1));
    repeat (2) @(posedge clk);
    #1;
    check("reset_phase", 16'(phase), 16'd0);
    check("reset_outs", 16'(obs), 16'(9'b1_0000_0000));
    reset = 1'b0;
  endtask

  // Drive one instruction from phase 0. abort_phase (0..7) asserts reset in
  // the middle of that phase; any other value runs the instruction to the end.
  task automatic run_instr(input logic [2:0] op, input logic z6, input logic [4:0] a,
                           input logic [4:0] start, input int abort_phase);
    logic [7:0] sel_m, rd_m, wr_m, ld_ir_m, inc_m, ld_pc_m, ld_ac_m, data_e_m;
    logic [8:0] exp_o;
    logic [4:0] pc, exp_pc;
    logic       alu;
    int         last;
    alu      = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    sel_m    = 8'b0000_1111;
    rd_m     = 8'b0000_1110 | (alu ? 8'b1110_0000 : 8'h00);
    ld_ir_m  = 8'b0000_1100;
    inc_m    = ((op != HLT) ? 8'b0001_0000 : 8'h00) | ((op == SKZ && z6) ? 8'b0100_0000 : 8'h00);
    ld_pc_m  = (op == JMP) ? 8'b1100_0000 : 8'h00;
    ld_ac_m  = alu ? 8'b1000_0000 : 8'h00;
    data_e_m = (op == STO) ? 8'b1100_0000 : 8'h00;
    wr_m     = (op == STO) ? 8'b1000_0000 : 8'h00;
    pc       = start;
    last     = (op == HLT) ? 4 : 7;
    for (int p = 0; p <= last; p++) begin
      @(negedge clk);
      // Opcode is garbage until the IR has settled; it must not matter.
      opcode = (p < 4) ? 3'($urandom_range(0, 7)) : op;
      zero   = (p == 6) ? z6 : 1'($urandom_range(0, 1));
      #2;
      exp_o = {sel_m[p], rd_m[p], wr_m[p], ld_ir_m[p], inc_m[p],
               ld_pc_m[p], ld_ac_m[p], data_e_m[p], 1'b0};
      check($sformatf("phase op=%0d p=%0d", op, p), 16'(phase), 16'(p));
      check($sformatf("outs op=%0d p=%0d", op, p), 16'(obs), 16'(exp_o));
      if (ld_pc) pc = a;
      else if (inc_pc) pc = pc + 5'd1;
      if (p == 4) begin
        check($sformatf("pc_after_p4 op=%0d", op), 16'(pc),
              16'((op == HLT) ? start : 5'(start + 5'd1)));
      end
      if (p == abort_phase) begin
        #1 reset = 1'b1;
        #1;
        check("abort_phase_async", 16'(phase), 16'd0);
        check("abort_outs_async", 16'(obs), 16'(9'b1_0000_0000));
        @(posedge clk);
        #1;
        check("abort_outs_held", 16'(obs), 16'(9'b1_0000_0000));
        reset = 1'b0;
        return;
      end
    end
    if (op == HLT) begin
      repeat (22) begin
        @(negedge clk);
        opcode = 3'($urandom_range(0, 7));
        zero   = 1'($urandom_range(0, 1));
        #2;
        check("halt_phase", 16'(phase), 16'd5);
        check("halt_outs", 16'(obs), 16'(9'b0_0000_0001));
        if (ld_pc) pc = a;
        else if (inc_pc) pc = pc + 5'd1;
      end
      check("halt_pc", 16'(pc), 16'(start));
      do_reset();
    end else begin
      @(posedge clk);
      #1;
      if (op == JMP) exp_pc = a;
      else if (op == SKZ && z6) exp_pc = start + 5'd2;
      else exp_pc = start + 5'd1;
      check($sformatf("pc_end op=%0d", op), 16'(pc), 16'(exp_pc));
      check($sformatf("wrap op=%0d", op), 16'(phase), 16'd0);
    end
  endtask

  initial begin
    do_reset();
    // directed steps
    run_instr(LDA, 1'b0, 5'($urandom_range(0, 31)), 5'd0, 99);
    run_instr(STO, 1'b1, 5'($urandom_range(0, 31)), 5'd1, 99);
    run_instr(JMP, 1'b0, 5'b10010, 5'd3, 99);
    run_instr(SKZ, 1'b1, 5'd4, 5'd7, 99);
    run_instr(SKZ, 1'b0, 5'd4, 5'd7, 99);
    run_instr(ADD, 1'b1, 5'd9, 5'd31, 99);
    run_instr(HLT, 1'b0, 5'd20, 5'd12, 99);
    run_instr(STO, 1'b0, 5'd2, 5'd5, 6);
    run_instr(LDA, 1'b0, 5'd2, 5'd0, 99);
    run_instr(STO, 1'b1, 5'd3, 5'd1, 3);
    run_instr(XOR, 1'b0, 5'd3, 5'd0, 99);
    // randomized steps
    for (int i = 0; i < 40; i++) begin
      run_instr(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 99);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cisc_seq_ctrl.md
Name: cisc_seq_ctrl

Overview:
- Multi-cycle instruction sequencer for the 8-bit accumulator CISC core.
- Steps each instruction through a fixed 8-phase fetch/execute cycle.
- Drives the program counter (ld_pc/inc_pc), the address mux, the instruction register, the accumulator, and memory read/write strobes.
- Sits between the instruction register opcode field and every datapath load/enable.

Parameters:
- PHASE_W, 3, width of the phase counter; fixed at 3 for 8 phases.
- OP_W, 3, opcode width (instruction bits [7:5]); the operand address is bits [4:0] and goes to the PC and memory.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high. Forces phase=INST_ADDR and clears halted.
- opcode  input  3  IR[7:5]. 000 HLT, 001 SKZ, 010 ADD, 011 AND, 100 XOR, 101 LDA, 110 STO, 111 JMP.
- zero  input  1  accumulator==0 flag from the ALU.
- sel  output  1  address mux select: 1=PC, 0=IR operand address.
- rd  output  1  memory read enable.
- wr  output  1  memory write strobe.
- ld_ir  output  1  instruction register load.
- inc_pc  output  1  PC increment request.
- ld_pc  output  1  PC load from IR[4:0]. The PC gives ld_pc priority over inc_pc.
- ld_ac  output  1  accumulator load.
- data_e  output  1  accumulator drives the data bus.
- halted  output  1  high while the sequencer is stopped.
- phase  output  3  current phase, for debug and verification.

Behaviour:
- Registered state:
  - 3-bit phase counter. Reset value 0 (INST_ADDR).
  - halted flag. Reset value 0.
- Phase advance:
  - When halted=0, phase increments by 1 each clk.
  - Phase wraps from 7 to 0 with no idle cycle.
  - One instruction takes exactly 8 clk.
- Outputs:
  - All outputs are combinational decodes of (phase, opcode, zero, halted). There is no extra latency.
  - ALUOP = ADD | AND | XOR | LDA.
  - Any output not listed for a phase is 0.
- Phase decode:
  - 0 INST_ADDR: sel=1.
  - 1 INST_FETCH: sel=1, rd=1.
  - 2 INST_LOAD: sel=1, rd=1, ld_ir=1.
  - 3 IDLE: sel=1, rd=1, ld_ir=1. The IR is stable from the end of phase 3, so opcode is valid from phase 4.
  - 4 OP_ADDR: inc_pc = (opcode!=HLT). If opcode==HLT, halted is set at the clk edge ending phase 4.
  - 5 OP_FETCH: rd=ALUOP.
  - 6 ALU_OP: rd=ALUOP; inc_pc=(SKZ & zero); ld_pc=JMP; data_e=STO.
  - 7 STORE: rd=ALUOP; ld_ac=ALUOP; ld_pc=JMP; wr=STO; data_e=STO.
- Reset values (phase 0, halted=0): sel=1. rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e are all 0. halted=0, phase=0.
- HLT handling:
  - Once halted=1, phase freezes at 5.
  - While halted=1, all strobes are 0 and sel=0.
  - PC holds the address of the HLT instruction.
  - Only reset clears halted.
- SKZ handling:
  - With zero=1 in phase 6, the PC receives a second increment in that instruction, skipping one word.
  - zero is sampled only in phase 6; it is don't-care elsewhere.
- JMP handling:
  - ld_pc is asserted in phases 6 and 7. The PC ends the instruction holding IR[4:0].
  - The phase-4 increment is overwritten.
- Opcode changes outside phases 4–7 must not affect any output.
- Reset mid-instruction:
  - Phase returns to 0 immediately (asynchronous), and all strobes drop except sel=1.
  - A partially executed STO must not produce wr after reset deassertion until phase 7 of a new instruction.
- wr asserts only in phase 7. No output glitches to 1 in a phase where it is specified 0.

Test Plan:
- Reset release, opcode=LDA(101), zero=0: 8 clk → phase 0..7 then 0. rd=1 in phases 1,2,3,5,6,7; ld_ac=1 only in phase 7; inc_pc=1 only in phase 4.
- opcode=STO(110): data_e=1 in phases 6,7; wr=1 only in phase 7; rd=0 in phases 5–7; ld_ac never 1.
- opcode=JMP(111), paired with the pc block and IR[4:0]=5'b10010, PC starting at 3 → PC=4 after phase 4 and 18 after phase 7. ld_pc=1 in phases 6,7.
- opcode=SKZ(001), PC starting at 7: with zero=1, PC=9 at the end of the instruction; with zero=0, PC=8.
- opcode=HLT(000) at PC=12 → halted=1 after the phase-4 edge; phase stays 5 for 20+ clk; all strobes 0; PC stays 12. Asserting reset → halted=0, phase=0.
- Assert reset asynchronously mid-phase 6 of STO → phase=0 without waiting for clk, wr never pulses. After release, a normal 8-phase fetch resumes.
